// File: rtl/timer_sequencer.sv
// Bus initiator that programs the counter/timer peripheral for one job, polls its
// finish flag until done/timeout/abort, reads the count back and returns a response.
module timer_sequencer #(
  parameter int COUNTER_WIDTH = 32,
  parameter int TIMEOUT_WIDTH = 16,
  parameter int POLL_INTERVAL = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [COUNTER_WIDTH-1:0] cmd_load_i,
  input  logic [COUNTER_WIDTH-1:0] cmd_reload_i,
  input  logic [2:0]               cmd_mode_i,
  input  logic [TIMEOUT_WIDTH-1:0] cmd_timeout_i,
  input  logic                     abort_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [1:0]               rsp_status_o,
  output logic [COUNTER_WIDTH-1:0] rsp_count_o,
  output logic [TIMEOUT_WIDTH-1:0] rsp_cycles_o,
  output logic                     busy_o,
  output logic                     t_en_o,
  output logic                     t_we_o,
  output logic                     t_re_o,
  output logic [1:0]               t_addr_o,
  output logic [COUNTER_WIDTH-1:0] t_load_o,
  output logic [1:0]               t_size_o,
  input  logic [COUNTER_WIDTH-1:0] t_rdata_i,
  input  logic                     t_done_i
);

  localparam int             PW        = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [PW-1:0]  POLL_LAST = PW'(POLL_INTERVAL - 1);

  localparam logic [1:0] ST_DONE    = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ABORT   = 2'b10;

  localparam logic [1:0] A_CNT    = 2'b00;
  localparam logic [1:0] A_MODE   = 2'b01;
  localparam logic [1:0] A_RELOAD = 2'b10;
  localparam logic [1:0] A_STATUS = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_WR_LOAD, S_WR_RELOAD, S_WR_MODE, S_RUN, S_RD_CNT, S_STOP, S_RESP
  } state_e;

  typedef struct packed {
    logic [COUNTER_WIDTH-1:0] load;
    logic [COUNTER_WIDTH-1:0] reload;
    logic [2:0]               mode;
    logic [TIMEOUT_WIDTH-1:0] timeout;
  } job_t;

  state_e                   state_q, state_d;
  job_t                     job_q, job_d;
  logic [TIMEOUT_WIDTH-1:0] cyc_q, cyc_d, cyc_nxt, cyc_sat;
  logic [PW-1:0]            poll_q, poll_d;
  logic [1:0]               status_q, status_d;
  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  logic [TIMEOUT_WIDTH-1:0] rcyc_q, rcyc_d;
  logic                     poll_hit, fin_seen, timed_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      job_q    <= '0;
      cyc_q    <= '0;
      poll_q   <= '0;
      status_q <= '0;
      count_q  <= '0;
      rcyc_q   <= '0;
    end else begin
      state_q  <= state_d;
      job_q    <= job_d;
      cyc_q    <= cyc_d;
      poll_q   <= poll_d;
      status_q <= status_d;
      count_q  <= count_d;
      rcyc_q   <= rcyc_d;
    end
  end

  assign cyc_nxt   = cyc_q + TIMEOUT_WIDTH'(1);
  assign cyc_sat   = (&cyc_q) ? cyc_q : cyc_nxt;
  assign poll_hit  = (poll_q == POLL_LAST);
  // The finish flag is only trusted on a completed status read.
  assign fin_seen  = poll_hit && t_done_i && t_rdata_i[0];
  assign timed_out = (job_q.timeout != '0) && (cyc_nxt == job_q.timeout);

  always_comb begin
    state_d     = state_q;
    job_d       = job_q;
    cyc_d       = cyc_q;
    poll_d      = poll_q;
    status_d    = status_q;
    count_d     = count_q;
    rcyc_d      = rcyc_q;
    cmd_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    t_en_o      = 1'b0;
    t_we_o      = 1'b0;
    t_re_o      = 1'b0;
    t_addr_o    = A_CNT;
    t_load_o    = '0;
    case (state_q)
      S_IDLE: begin
        cmd_ready_o = rst_n;
        if (cmd_valid_i && rst_n) begin
          job_d   = '{load: cmd_load_i, reload: cmd_reload_i, mode: cmd_mode_i,
                      timeout: cmd_timeout_i};
          state_d = S_WR_LOAD;
        end
      end
      S_WR_LOAD: begin
        t_en_o   = 1'b1;
        t_we_o   = 1'b1;
        t_addr_o = A_CNT;
        t_load_o = job_q.load;
        if (t_done_i) state_d = S_WR_RELOAD;
      end
      S_WR_RELOAD: begin
        t_en_o   = 1'b1;
        t_we_o   = 1'b1;
        t_addr_o = A_RELOAD;
        t_load_o = job_q.reload;
        if (t_done_i) state_d = S_WR_MODE;
      end
      S_WR_MODE: begin
        // Mode goes last so the timer starts counting fully configured.
        t_en_o   = 1'b1;
        t_we_o   = 1'b1;
        t_addr_o = A_MODE;
        t_load_o = COUNTER_WIDTH'(job_q.mode);
        if (t_done_i) begin
          cyc_d   = '0;
          poll_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        t_en_o = 1'b1;
        cyc_d  = cyc_sat;
        poll_d = poll_hit ? '0 : PW'(poll_q + PW'(1));
        if (poll_hit) begin
          t_re_o   = 1'b1;
          t_addr_o = A_STATUS;
        end
        if (fin_seen || abort_i || timed_out) begin
          status_d = fin_seen ? ST_DONE : (abort_i ? ST_ABORT : ST_TIMEOUT);
          rcyc_d   = cyc_sat;
          state_d  = S_RD_CNT;
        end
      end
      S_RD_CNT: begin
        t_en_o   = 1'b1;
        t_re_o   = 1'b1;
        t_addr_o = A_CNT;
        if (t_done_i) begin
          count_d = t_rdata_i;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Mode 0 parks the timer and clears its finish flag for the next job.
        t_en_o   = 1'b1;
        t_we_o   = 1'b1;
        t_addr_o = A_MODE;
        if (t_done_i) state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o       = (state_q != S_IDLE);
  assign t_size_o     = 2'b10;
  assign rsp_status_o = status_q;
  assign rsp_count_o  = count_q;
  assign rsp_cycles_o = rcyc_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench: two sequencers (poll interval 1 and 4), each driving a small
// behavioural timer model, checked against hand-computed results.
module tb_timer_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cmd_valid, rsp_ready;
  logic [31:0] cmd_load, cmd_reload;
  logic [2:0]  cmd_mode;
  logic [15:0] cmd_timeout;
  logic        abort, t_done;

  logic [1:0]  cmd_ready, rsp_valid, busy, t_en, t_we, t_re;
  logic [1:0]  rsp_status [2];
  logic [31:0] rsp_count  [2];
  logic [15:0] rsp_cycles [2];
  logic [1:0]  t_addr     [2];
  logic [31:0] t_load     [2];
  logic [1:0]  t_size     [2];

  int          n_run  = 0;
  int          n_fail = 0;
  logic [31:0] re_mask;
  logic [2:0]  last_mode;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gi
    logic [31:0] cnt_m, rel_m, rdata;
    logic [2:0]  mode_m;
    logic        fin_m;

    timer_sequencer #(.COUNTER_WIDTH(32), .TIMEOUT_WIDTH(16), .POLL_INTERVAL(g == 0 ? 1 : 4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid_i(cmd_valid[g]), .cmd_ready_o(cmd_ready[g]),
      .cmd_load_i(cmd_load), .cmd_reload_i(cmd_reload), .cmd_mode_i(cmd_mode),
      .cmd_timeout_i(cmd_timeout), .abort_i(abort),
      .rsp_valid_o(rsp_valid[g]), .rsp_ready_i(rsp_ready[g]),
      .rsp_status_o(rsp_status[g]), .rsp_count_o(rsp_count[g]), .rsp_cycles_o(rsp_cycles[g]),
      .busy_o(busy[g]), .t_en_o(t_en[g]), .t_we_o(t_we[g]), .t_re_o(t_re[g]),
      .t_addr_o(t_addr[g]), .t_load_o(t_load[g]), .t_size_o(t_size[g]),
      .t_rdata_i(rdata), .t_done_i(t_done)
    );

    always_comb begin
      rdata = '0;
      case (t_addr[g])
        2'd0: rdata = cnt_m;
        2'd1: rdata = {29'd0, mode_m};
        2'd2: rdata = rel_m;
        2'd3: rdata = {31'd0, fin_m};
        default: rdata = '0;
      endcase
    end

    // Timer model: down mode flags finish one tick after reaching 0; periodic reloads without flagging.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_m <= '0; rel_m <= '0; mode_m <= '0; fin_m <= 1'b0;
      end else if (t_en[g] && t_done) begin
        if (t_we[g]) begin
          case (t_addr[g])
            2'd0: cnt_m <= t_load[g];
            2'd1: begin mode_m <= t_load[g][2:0]; fin_m <= 1'b0; end
            2'd2: rel_m <= t_load[g];
            default: ;
          endcase
        end else begin
          case (mode_m)
            3'd1, 3'd3, 3'd5: cnt_m <= cnt_m + 32'd1;
            3'd2: if (cnt_m == 0) fin_m <= 1'b1; else cnt_m <= cnt_m - 32'd1;
            3'd4: cnt_m <= (cnt_m == 0) ? rel_m : cnt_m - 32'd1;
            default: ;
          endcase
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input int idx, input logic [31:0] ld, input logic [31:0] rl,
                       input logic [2:0] md, input logic [15:0] to);
    cmd_load = ld; cmd_reload = rl; cmd_mode = md; cmd_timeout = to;
    chk("cmd_ready_idle", cmd_ready[idx], 1);
    cmd_valid[idx] = 1'b1;
    step();
    cmd_valid[idx] = 1'b0;
  endtask

  // Advances until rsp_valid, tracking status polls and mode writes; lat counts cycles since accept.
  task automatic wait_rsp(input int idx, input int abort_at, inout int lat);
    re_mask   = '0;
    last_mode = 3'h7;
    while (!rsp_valid[idx] && lat < 200) begin
      if (t_en[idx] && t_re[idx] && t_addr[idx] == 2'd3 && lat >= 4 && lat < 36)
        re_mask[lat-4] = 1'b1;
      if (t_en[idx] && t_we[idx] && t_addr[idx] == 2'd1) last_mode = t_load[idx][2:0];
      abort = (lat == abort_at);
      step();
      lat++;
    end
    abort = 1'b0;
  endtask

  task automatic ack(input int idx);
    rsp_ready[idx] = 1'b1;
    step();
    rsp_ready[idx] = 1'b0;
    chk("ack_valid_drop", rsp_valid[idx], 0);
    chk("ack_ready_back", cmd_ready[idx], 1);
  endtask

  int lat;

  initial begin
    rst_n = 1'b0; cmd_valid = '0; rsp_ready = '0; abort = 1'b0; t_done = 1'b1;
    cmd_load = '0; cmd_reload = '0; cmd_mode = '0; cmd_timeout = '0;
    step(); step();
    chk("rst_cmd_ready", cmd_ready[0], 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_t_strobes", {t_en, t_we, t_re}, 0);
    chk("rst_t_addr", t_addr[0], 0);
    chk("rst_t_load", t_load[0], 0);
    chk("rst_rsp", {rsp_status[0], rsp_count[0], rsp_cycles[0]}, 0);
    chk("t_size", t_size[1], 2'b10);
    rst_n = 1'b1;
    step();

    // Down count from 5, poll every cycle: flag seen in 7th RUN cycle.
    issue(0, 32'd5, 32'd0, 3'd2, 16'd0);
    chk("t1_wrload", {t_en[0], t_we[0], t_addr[0], t_load[0]}, {1'b1, 1'b1, 2'd0, 32'd5});
    chk("t1_busy", busy[0], 1);
    step();
    chk("t1_wrreload_addr", t_addr[0], 2'd2);
    step();
    chk("t1_wrmode", {t_addr[0], t_load[0]}, {2'd1, 32'd2});
    step();
    chk("t1_run_we", {t_en[0], t_we[0]}, 2'b10);
    lat = 4;
    wait_rsp(0, -1, lat);
    chk("t1_latency", lat, 13);
    chk("t1_status", rsp_status[0], 2'b00);
    chk("t1_count", rsp_count[0], 0);
    chk("t1_cycles", rsp_cycles[0], 7);
    chk("t1_polls", re_mask, 32'h7F);
    ack(0);

    // Free-run from 100 with timeout 10.
    issue(0, 32'd100, 32'd0, 3'd3, 16'd10);
    lat = 1;
    wait_rsp(0, -1, lat);
    chk("t2_latency", lat, 16);
    chk("t2_status", rsp_status[0], 2'b01);
    chk("t2_cycles", rsp_cycles[0], 10);
    chk("t2_count", rsp_count[0], 110);
    chk("t2_stop_mode", last_mode, 0);
    ack(0);

    // Periodic; abort in IDLE ignored, abort in 6th RUN cycle taken.
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t3_idle_abort_busy", busy[0], 0);
    chk("t3_idle_abort_rsp", rsp_valid[0], 0);
    issue(0, 32'd3, 32'd3, 3'd4, 16'd0);
    lat = 1;
    wait_rsp(0, 9, lat);
    chk("t3_latency", lat, 12);
    chk("t3_status", rsp_status[0], 2'b10);
    chk("t3_cycles", rsp_cycles[0], 6);
    chk("t3_count", rsp_count[0], 1);
    ack(0);

    // Poll interval 4: status reads in RUN cycles 4 and 8.
    issue(1, 32'd5, 32'd0, 3'd2, 16'd0);
    lat = 1;
    wait_rsp(1, -1, lat);
    chk("t4_latency", lat, 14);
    chk("t4_status", rsp_status[1], 2'b00);
    chk("t4_cycles", rsp_cycles[1], 8);
    chk("t4_count", rsp_count[1], 0);
    chk("t4_polls", re_mask, 32'h88);
    ack(1);

    // t_done stall in WR_RELOAD, then rsp_ready back-pressure.
    issue(0, 32'd2, 32'd7, 3'd2, 16'd0);
    step();
    t_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t5_stall_hold", {t_en[0], t_we[0], t_addr[0], t_load[0]}, {1'b1, 1'b1, 2'd2, 32'd7});
      if (i == 3) t_done = 1'b1;
      step();
    end
    chk("t5_after_stall", t_addr[0], 2'd1);
    lat = 6;
    wait_rsp(0, -1, lat);
    chk("t5_latency", lat, 13);
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_valid", {rsp_valid[0], cmd_ready[0]}, 2'b10);
      chk("t5_hold_rsp", {rsp_status[0], rsp_count[0], rsp_cycles[0]}, {2'b00, 32'd0, 16'd4});
      step();
    end
    ack(0);

    // Reset in the middle of RUN.
    issue(0, 32'd0, 32'd0, 3'd3, 16'd0);
    repeat (6) step();
    chk("t6_in_run", {busy[0], t_en[0]}, 2'b11);
    rst_n = 1'b0;
    step();
    chk("t6_rst_outs", {busy[0], rsp_valid[0], t_en[0], t_we[0], t_re[0], cmd_ready[0]}, 0);
    chk("t6_rst_rsp", {rsp_status[0], rsp_count[0], rsp_cycles[0], t_addr[0], t_load[0]}, 0);
    rst_n = 1'b1;
    step();
    issue(0, 32'd1, 32'd0, 3'd2, 16'd0);
    lat = 1;
    wait_rsp(0, -1, lat);
    chk("t6_latency", lat, 9);
    chk("t6_rsp", {rsp_status[0], rsp_cycles[0]}, {2'b00, 16'd3});
    ack(0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_sequencer.md
# timer_sequencer

Bus initiator that drives the register-port side of the counter/timer peripheral. It accepts one timer job on a valid/ready command port and programs the timer (load, reload, mode). It then keeps the timer enabled while polling its status register until the finish flag rises, a timeout expires or an abort arrives. Finally it reads the counter back, returns the timer to idle mode and presents a result on a valid/ready response port.

## Interface
- COUNTER_WIDTH, 32, width of timer data and of cmd_load/cmd_reload/rsp_count
- TIMEOUT_WIDTH, 16, width of cmd_timeout and rsp_cycles
- POLL_INTERVAL, 1, RUN cycles per status read (≥1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  job request
- cmd_ready  out  1  high only in IDLE
- cmd_load  in  COUNTER_WIDTH  initial counter value
- cmd_reload  in  COUNTER_WIDTH  periodic reload value
- cmd_mode  in  3  timer mode code (0 idle, 1 up, 2 down, 3 free-run, 4 periodic, 5 up/down)
- cmd_timeout  in  TIMEOUT_WIDTH  max RUN cycles; 0 = no timeout
- abort  in  1  terminate job while in RUN
- rsp_valid  out  1  result available
- rsp_ready  in  1  result consumed
- rsp_status  out  2  00 done, 01 timeout, 10 aborted
- rsp_count  out  COUNTER_WIDTH  counter value read at end
- rsp_cycles  out  TIMEOUT_WIDTH  number of RUN cycles spent
- busy  out  1  state != IDLE
- t_en, t_we, t_re  out  1 each  timer enable / write / read strobes
- t_addr  out  2  timer register: 00 counter, 01 mode, 10 reload, 11 status
- t_load  out  COUNTER_WIDTH  timer write data
- t_size  out  2  constant 2'b10
- t_rdata  in  COUNTER_WIDTH  timer read data, combinational in same cycle as t_en&t_re
- t_done  in  1  timer ready; bus phases advance only when high

## Operation
- State register: IDLE, WR_LOAD, WR_RELOAD, WR_MODE, RUN, RD_CNT, STOP, RESP. Timer-side outputs decoded from state; unused t_* = 0, t_load = 0 outside write states.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, capture all cmd_* and go to WR_LOAD.
- WR_LOAD: t_en=1, t_we=1, t_addr=00, t_load=cmd_load. Then WR_RELOAD.
- WR_RELOAD: write cmd_reload to 10. Then WR_MODE.
- WR_MODE: write zero-extended cmd_mode to 01. Clear cycle counter and poll counter. Go to RUN.
  - Mode is written last so counting starts only after full configuration.
- Write and read states hold when t_done=0: outputs stay unchanged and the state does not advance.
- RUN: t_en=1, t_we=0 (timer counts every cycle). cyc increments each RUN cycle, saturating.
  - Poll counter wraps at POLL_INTERVAL-1; on that cycle t_re=1, t_addr=11, and t_rdata[0] is sampled.
  - Exit priority, same cycle: finish bit seen → DONE; else abort → ABORT; else cyc+1==cmd_timeout (timeout≠0) → TIMEOUT.
  - On exit, latch rsp_status and rsp_cycles = cyc+1 (includes exit cycle). Go to RD_CNT.
  - abort outside RUN is ignored.
- RD_CNT: t_en=1, t_re=1, t_addr=00. Capture t_rdata into rsp_count; this is the pre-edge value. Then STOP.
- STOP: write 0 to 01, forcing timer mode IDLE and clearing its finish flag. Then RESP.
- RESP: rsp_valid=1, with rsp_* stable until rsp_ready. On handshake go to IDLE.
  - A new command is accepted no earlier than the cycle after the handshake.
- cyc and comparisons are TIMEOUT_WIDTH unsigned. With cmd_timeout=0, a job that never finishes stays in RUN until abort.

## Timing
- Reset: state IDLE; rsp_valid, busy, t_en, t_we, t_re = 0; t_addr = 0; t_load = 0; rsp_* = 0. cmd_ready=0 while rst_n low, 1 after release.
- Command accepted in cycle N:
  - WR_LOAD at N+1, WR_RELOAD at N+2, WR_MODE at N+3, first RUN cycle at N+4 (t_done=1).
  - Exit decided in RUN cycle E: RD_CNT at E+1, STOP at E+2, rsp_valid first high at E+3.
- Finish detection latency is up to POLL_INTERVAL-1 cycles after the timer flag sets.
- Reset mid-job returns to IDLE immediately. No response is issued, and the timer is not written.

## Test plan
- DOWN, load 5, POLL_INTERVAL 1, timeout 0, accept at N → writes at N+1..N+3; status read sees 1 at N+10; rsp_valid at N+13 with status 00, count 0, cycles 7.
- FREE_RUN, load 100, timeout 10 → status 01, cycles 10, count 110; STOP writes mode 0.
- PERIODIC, load 3, reload 3; abort pulsed in 6th RUN cycle → status 10, cycles 6; abort pulsed in IDLE ignored.
- Same as first test with POLL_INTERVAL 4 → t_re pulses every 4th RUN cycle; cycles 8 (first poll after flag).
- t_done low 3 cycles in WR_RELOAD → t_addr=10 and data held 4 cycles; rsp_ready low 5 cycles in RESP → rsp_* stable, cmd_ready 0.
- rst_n asserted in RUN → all outputs at reset values next cycle; after release, a new command is accepted normally.
